minisrc_multicycle_cpu: RTL and testbench

- Multi-cycle 32-bit MiniSRC-subset processor core.
- Fetches, decodes and executes one instruction at a time over a single shared word-addressed memory port with a ready handshake.
- Contains the PC, IR, a 16x32 register file, the HI/LO registers, an ALU with a signed multiplier, and the control FSM.
- The clock is supplied externally by the system clock generator.

---
 rtl/minisrc_multicycle_cpu_if.sv | 11 +
 rtl/minisrc_multicycle_cpu.sv | 153 +++++++++++++++
 tb/tb_minisrc_multicycle_cpu.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minisrc_multicycle_cpu_if.sv
// minisrc_multicycle_cpu_if: shared word-addressed memory port with ready handshake
interface minisrc_multicycle_cpu_if;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [31:0] iMemData;
  logic        iMemRdy;
  logic        oMemRead;
  logic        oMemWrite;
  modport master(output oMemAddr, oMemData, oMemRead, oMemWrite, input iMemData, iMemRdy);
  modport slave(input oMemAddr, oMemData, oMemRead, oMemWrite, output iMemData, iMemRdy);
endinterface

// File: rtl/minisrc_multicycle_cpu.sv
// minisrc_multicycle_cpu: multi-cycle MiniSRC-subset core; one instruction at a time over a
// single memory port whose requests are registered and always separated by an idle cycle.
module minisrc_multicycle_cpu #(
  parameter logic [31:0] START_PC = 32'd0
) (
  input logic iClk,
  input logic nRst,
  minisrc_multicycle_cpu_if.master mem
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101, OP_ORI = 5'b01110, OP_MUL = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, s_q, s_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [63:0] res_q, res_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [31:0] c, ea, alu;
  logic [63:0] prod;
  logic        exec_op;
  assign op   = ir_q[31:27];
  assign ra   = ir_q[26:23];
  assign rb   = ir_q[22:19];
  assign rc   = ir_q[18:15];
  assign c    = {{13{ir_q[18]}}, ir_q[18:0]};
  assign ea   = a_q + c;
  // Low 64 bits of the sign-extended product equal the signed 32x32 product
  assign prod = {{32{s_q[31]}}, s_q} * {{32{a_q[31]}}, a_q};
  assign mem.oMemAddr  = addr_q;
  assign mem.oMemData  = data_q;
  assign mem.oMemRead  = rd_q;
  assign mem.oMemWrite = wr_q;
  always_comb begin
    exec_op = 1'b1;
    alu     = ea;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_MUL: alu = ea;
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_ANDI: alu = a_q & c;
      OP_ORI:  alu = a_q | c;
      OP_MFHI: alu = hi_q;
      OP_MFLO: alu = lo_q;
      default: exec_op = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        rd_d    = 1'b1;
        addr_d  = pc_q;
      end
      S_FETCH: if (mem.iMemRdy) begin
        ir_d    = mem.iMemData;
        pc_d    = pc_q + 32'd1;
        rd_d    = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = regs_q[rb];
        b_d     = regs_q[rc];
        s_d     = regs_q[ra];
        state_d = op == OP_HALT ? S_HALT : exec_op ? S_EXEC : S_FETCH;
        rd_d    = op != OP_HALT && !exec_op;
        addr_d  = rd_d ? pc_q : addr_q;
      end
      S_EXEC: begin
        res_d   = op == OP_MUL ? prod : {32'd0, alu};
        rd_d    = op == OP_LD;
        wr_d    = op == OP_ST;
        addr_d  = rd_d || wr_d ? ea : addr_q;
        data_d  = wr_d ? s_q : data_q;
        state_d = rd_d || wr_d ? S_MEM : S_WB;
      end
      S_MEM: if (mem.iMemRdy) begin
        res_d   = rd_q ? {32'd0, mem.iMemData} : res_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        // st also passes through WB so the bus idles a cycle before the next fetch
        state_d = S_WB;
      end
      S_WB: begin
        if (op == OP_MUL) begin
          hi_d = res_q[63:32];
          lo_d = res_q[31:0];
        end else if (op != OP_ST) begin
          regs_d[ra] = res_q[31:0];
        end
        state_d = S_FETCH;
        rd_d    = 1'b1;
        addr_d  = pc_q;
      end
      default: state_d = S_HALT;
    endcase
    regs_d[0] = '0;
  end
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_minisrc_multicycle_cpu.sv
// tb_minisrc_multicycle_cpu: directed programs checked through the memory port (stores, request
// timing, stalls, halt and async reset)
module tb_minisrc_multicycle_cpu;
  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100, AND = 5'b00101, OR = 5'b00110, ADDI = 5'b01100;
  localparam logic [4:0] ANDI = 5'b01101, ORI = 5'b01110, MUL = 5'b10000;
  localparam logic [4:0] MFHI = 5'b11000, MFLO = 5'b11001, NOP = 5'b11010, HALT = 5'b11011;
  logic iClk = 1'b0;
  logic nRst = 1'b1;
  logic rdy = 1'b1;
  int checks = 0;
  int errors = 0;
  minisrc_multicycle_cpu_if bus();
  minisrc_multicycle_cpu #(.START_PC(32'd0)) dut (.iClk(iClk), .nRst(nRst), .mem(bus));
  always #5 iClk = ~iClk;
  logic [31:0] prog [256];
  logic [31:0] wmem [256];
  int start_at [256];
  int wr_at [256];
  int wr_n [256];
  int cyc, wr_cnt, req_cnt;
  logic prev_req, prev_done, both_seen, gap_viol, rq;
  assign bus.iMemData = prog[bus.oMemAddr[7:0]];
  assign bus.iMemRdy  = rdy;
  always @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cyc = 0; wr_cnt = 0; req_cnt = 0;
      prev_req = 1'b0; prev_done = 1'b0; both_seen = 1'b0; gap_viol = 1'b0;
      for (int i = 0; i < 256; i++) begin
        start_at[i] = -1; wr_at[i] = -1; wr_n[i] = 0; wmem[i] = '0;
      end
    end else begin
      rq = bus.oMemRead || bus.oMemWrite;
      if (rq && !prev_req) req_cnt++;
      if (bus.oMemRead && !prev_req && start_at[bus.oMemAddr[7:0]] < 0) start_at[bus.oMemAddr[7:0]] = cyc;
      if (bus.oMemWrite && rdy) begin
        wmem[bus.oMemAddr[7:0]] = bus.oMemData;
        wr_n[bus.oMemAddr[7:0]]++;
        wr_at[bus.oMemAddr[7:0]] = cyc;
        wr_cnt++;
      end
      if (bus.oMemRead && bus.oMemWrite) both_seen = 1'b1;
      if (prev_done && rq) gap_viol = 1'b1;
      prev_req  = rq;
      prev_done = rq && rdy;
      cyc++;
    end
  end
  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction
  function automatic logic [31:0] encr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction
  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 256; i++) prog[i] = w;
  endtask
  task automatic do_reset;
    nRst = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    nRst = 1'b1;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask
  task automatic wait_ld(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      if (bus.oMemRead && bus.oMemAddr == a) break;
      @(posedge iClk);
      #1;
    end
    checks++;
    if (!(bus.oMemRead && bus.oMemAddr == a)) begin
      errors++;
      $display("FAIL ld_wait: no read of addr %0d within budget (addr %0d read %0b)", a, bus.oMemAddr, bus.oMemRead);
    end
  endtask
  task automatic test_reset;
    fill(enc(NOP, 0, 0, 0));
    rdy = 1'b1;
    #1 nRst = 1'b0;
    @(negedge iClk);
    checks++;
    if ({bus.oMemRead, bus.oMemWrite, bus.oMemAddr, bus.oMemData} !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: rd %0b wr %0b addr %0h data %0h expected all 0", bus.oMemRead, bus.oMemWrite, bus.oMemAddr, bus.oMemData);
    end
    @(negedge iClk);
    nRst = 1'b1;
    run(1);
    checks++;
    if (bus.oMemRead !== 1'b1 || bus.oMemWrite !== 1'b0 || bus.oMemAddr !== 32'd0) begin
      errors++;
      $display("FAIL first_fetch: rd %0b wr %0b addr %0h expected rd 1 wr 0 addr 0", bus.oMemRead, bus.oMemWrite, bus.oMemAddr);
    end
    run(1);
    checks++;
    if (bus.oMemRead !== 1'b0) begin
      errors++;
      $display("FAIL decode_idle: rd %0b expected 0", bus.oMemRead);
    end
    run(1);
    checks++;
    if (bus.oMemRead !== 1'b1 || bus.oMemAddr !== 32'd1) begin
      errors++;
      $display("FAIL pc_inc1: rd %0b addr %0h expected rd 1 addr 1", bus.oMemRead, bus.oMemAddr);
    end
    run(2);
    checks++;
    if (bus.oMemRead !== 1'b1 || bus.oMemAddr !== 32'd2) begin
      errors++;
      $display("FAIL pc_inc2: rd %0b addr %0h expected rd 1 addr 2", bus.oMemRead, bus.oMemAddr);
    end
  endtask
  task automatic test_load_mul_store;
    fill(enc(HALT, 0, 0, 0));
    prog[0] = enc(LD, 1, 0, 20);
    prog[1] = enc(ADDI, 1, 1, 5);
    prog[2] = enc(LD, 2, 0, 21);
    prog[3] = enc(MUL, 2, 1, 0);
    prog[4] = enc(MFLO, 3, 0, 0);
    prog[5] = enc(ST, 3, 0, 2);
    prog[6] = enc(MFHI, 5, 0, 0);
    prog[7] = enc(ST, 5, 0, 3);
    prog[20] = 32'd5;
    prog[21] = 32'd5;
    rdy = 1'b1;
    do_reset;
    run(80);
    checks++;
    if (wr_n[2] !== 1 || wmem[2] !== 32'd50) begin
      errors++;
      $display("FAIL prog_store: writes to 2 = %0d data %0d expected 1 write of 50", wr_n[2], wmem[2]);
    end
    checks++;
    if (wr_at[2] < 0 || wr_at[2] >= 60) begin
      errors++;
      $display("FAIL prog_deadline: store cycle %0d expected within 60 cycles", wr_at[2]);
    end
    checks++;
    if (wr_n[3] !== 1 || wmem[3] !== 32'd0) begin
      errors++;
      $display("FAIL prog_hi: HI stored %0h (%0d writes) expected 0 (1 write)", wmem[3], wr_n[3]);
    end
    checks++;
    if (wr_cnt !== 2) begin
      errors++;
      $display("FAIL prog_wr_count: %0d writes expected 2", wr_cnt);
    end
    checks++;
    if (start_at[1] - start_at[0] !== 5 || start_at[2] - start_at[1] !== 4 || start_at[6] - start_at[5] !== 5) begin
      errors++;
      $display("FAIL latency: ld %0d addi %0d st %0d expected 5 4 5", start_at[1] - start_at[0], start_at[2] - start_at[1], start_at[6] - start_at[5]);
    end
    checks++;
    if (both_seen !== 1'b0 || gap_viol !== 1'b0) begin
      errors++;
      $display("FAIL bus_rules: both %0b no_gap %0b expected 0 0", both_seen, gap_viol);
    end
  endtask
  task automatic test_signed_mul;
    fill(enc(HALT, 0, 0, 0));
    prog[0] = enc(LDI, 1, 0, 19'h7FFFD);
    prog[1] = enc(LDI, 2, 0, 7);
    prog[2] = enc(MUL, 1, 2, 0);
    prog[3] = enc(MFLO, 3, 0, 0);
    prog[4] = enc(MFHI, 4, 0, 0);
    prog[5] = enc(ST, 3, 0, 10);
    prog[6] = enc(ST, 4, 0, 11);
    rdy = 1'b1;
    do_reset;
    run(60);
    checks++;
    if (wmem[10] !== 32'hFFFFFFEB || wmem[11] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL signed_mul: LO %0h HI %0h expected FFFFFFEB FFFFFFFF", wmem[10], wmem[11]);
    end
  endtask
  task automatic test_large_mul;
    fill(enc(HALT, 0, 0, 0));
    prog[0] = enc(LDI, 1, 0, 19'h10000);
    prog[1] = enc(LDI, 2, 0, 19'h10000);
    prog[2] = enc(MUL, 1, 2, 0);
    prog[3] = enc(MFHI, 4, 0, 0);
    prog[4] = enc(MFLO, 5, 0, 0);
    prog[5] = enc(ST, 4, 0, 12);
    prog[6] = enc(ST, 5, 0, 13);
    rdy = 1'b1;
    do_reset;
    run(60);
    checks++;
    if (wmem[12] !== 32'd1 || wmem[13] !== 32'd0 || wr_n[13] !== 1) begin
      errors++;
      $display("FAIL large_mul: HI %0h LO %0h (LO writes %0d) expected 1 0 (1)", wmem[12], wmem[13], wr_n[13]);
    end
  endtask
  task automatic test_alu;
    fill(enc(HALT, 0, 0, 0));
    prog[0]  = enc(LDI, 1, 0, 12);
    prog[1]  = enc(LDI, 2, 0, 10);
    prog[2]  = encr(ADD, 3, 1, 2);
    prog[3]  = encr(SUB, 4, 1, 2);
    prog[4]  = encr(AND, 5, 1, 2);
    prog[5]  = encr(OR, 6, 1, 2);
    prog[6]  = enc(ANDI, 7, 1, 6);
    prog[7]  = enc(ORI, 8, 1, 3);
    prog[8]  = encr(SUB, 9, 2, 1);
    prog[9]  = enc(NOP, 0, 0, 0);
    prog[10] = 32'hF8000000;
    for (int i = 0; i < 7; i++) prog[11 + i] = enc(ST, 4'(3 + i), 0, 19'(30 + i));
    rdy = 1'b1;
    do_reset;
    run(120);
    checks++;
    if (wmem[30] !== 32'd22 || wmem[31] !== 32'd2) begin
      errors++;
      $display("FAIL add_sub: %0d %0d expected 22 2", wmem[30], wmem[31]);
    end
    checks++;
    if (wmem[32] !== 32'd8 || wmem[33] !== 32'd14) begin
      errors++;
      $display("FAIL and_or: %0d %0d expected 8 14", wmem[32], wmem[33]);
    end
    checks++;
    if (wmem[34] !== 32'd4 || wmem[35] !== 32'd15) begin
      errors++;
      $display("FAIL andi_ori: %0d %0d expected 4 15", wmem[34], wmem[35]);
    end
    checks++;
    if (wmem[36] !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL sub_wrap: %0h expected FFFFFFFE", wmem[36]);
    end
    checks++;
    if (start_at[10] - start_at[9] !== 2 || start_at[11] - start_at[10] !== 2) begin
      errors++;
      $display("FAIL nop_latency: nop %0d unknown-op %0d expected 2 2", start_at[10] - start_at[9], start_at[11] - start_at[10]);
    end
  endtask
  task automatic test_stall;
    fill(enc(HALT, 0, 0, 0));
    prog[0] = enc(LD, 1, 0, 20);
    prog[1] = enc(ADDI, 0, 0, 7);
    prog[2] = encr(ADD, 2, 1, 0);
    prog[3] = enc(ST, 2, 0, 4);
    prog[4] = enc(ST, 0, 0, 5);
    prog[20] = 32'd9;
    rdy = 1'b0;
    do_reset;
    run(1);
    for (int i = 0; i < 3; i++) begin
      run(1);
      checks++;
      if (bus.oMemRead !== 1'b1 || bus.oMemAddr !== 32'd0) begin
        errors++;
        $display("FAIL fetch_stall: cycle %0d rd %0b addr %0h expected rd 1 addr 0", i, bus.oMemRead, bus.oMemAddr);
      end
    end
    rdy = 1'b1;
    wait_ld(32'd20);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run(1);
      checks++;
      if (bus.oMemRead !== 1'b1 || bus.oMemAddr !== 32'd20) begin
        errors++;
        $display("FAIL ld_stall: cycle %0d rd %0b addr %0h expected rd 1 addr 20", i, bus.oMemRead, bus.oMemAddr);
      end
    end
    rdy = 1'b1;
    run(60);
    checks++;
    if (wmem[4] !== 32'd9 || wr_n[4] !== 1) begin
      errors++;
      $display("FAIL stall_result: stored %0d (%0d writes) expected 9 (1)", wmem[4], wr_n[4]);
    end
    checks++;
    if (wmem[5] !== 32'd0 || wr_n[5] !== 1) begin
      errors++;
      $display("FAIL r0_write: R0 stored %0d (%0d writes) expected 0 (1)", wmem[5], wr_n[5]);
    end
    checks++;
    if (start_at[1] - start_at[0] !== 11) begin
      errors++;
      $display("FAIL stall_delay: ld took %0d cycles expected 11", start_at[1] - start_at[0]);
    end
  endtask
  task automatic test_halt_reset;
    fill(enc(HALT, 0, 0, 0));
    prog[0] = enc(LDI, 1, 0, 1);
    prog[2] = enc(ST, 1, 0, 7);
    rdy = 1'b1;
    do_reset;
    run(30);
    checks++;
    if (req_cnt !== 2 || wr_cnt !== 0 || bus.oMemRead !== 1'b0) begin
      errors++;
      $display("FAIL halt: requests %0d writes %0d rd %0b expected 2 0 0", req_cnt, wr_cnt, bus.oMemRead);
    end
    prog[0] = enc(LD, 1, 0, 20);
    prog[1] = enc(ST, 1, 0, 6);
    prog[2] = enc(HALT, 0, 0, 0);
    prog[20] = 32'h1234;
    do_reset;
    wait_ld(32'd20);
    rdy = 1'b0;
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (bus.oMemRead !== 1'b0 || bus.oMemAddr !== 32'd0) begin
      errors++;
      $display("FAIL async_abort: rd %0b addr %0h expected 0 0", bus.oMemRead, bus.oMemAddr);
    end
    rdy = 1'b1;
    @(negedge iClk);
    nRst = 1'b1;
    run(1);
    checks++;
    if (bus.oMemRead !== 1'b1 || bus.oMemAddr !== 32'd0) begin
      errors++;
      $display("FAIL restart: rd %0b addr %0h expected rd 1 addr 0", bus.oMemRead, bus.oMemAddr);
    end
    run(30);
    checks++;
    if (wmem[6] !== 32'h1234 || wr_cnt !== 1) begin
      errors++;
      $display("FAIL rerun_ld: stored %0h (%0d writes) expected 1234 (1)", wmem[6], wr_cnt);
    end
  endtask
  initial begin
    test_reset;
    test_load_mul_store;
    test_signed_mul;
    test_large_mul;
    test_alu;
    test_stall;
    test_halt_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
